ser_port: RTL and testbench

Parametrised serial port peripheral: 8N1 UART receiver feeding a receive FIFO, plus an 8N1 transmitter, behind a 4-register byte-wide bus slave. It succeeds the single-byte receive-only serial block: adds configurable bit timing, a deep receive buffer, transmit, and overrun/framing error flags. It sits on the GPU-side peripheral bus, and `rx_ready` drives the interrupt/poll line.

---
 rtl/ser_pkg.sv | 40 ++++
 rtl/ser_fifo.sv | 68 ++++++
 rtl/ser_port.sv | 208 ++++++++++++++++++++
 tb/tb_ser_port.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared constants and state encodings for the ser_port serial peripheral.
// Register map, status bit positions and the RX/TX FSM state enums.
package ser_pkg;

    localparam logic [1:0] SER_REG_STATUS = 2'd0;
    localparam logic [1:0] SER_REG_RXDATA = 2'd1;
    localparam logic [1:0] SER_REG_TXDATA = 2'd2;
    localparam logic [1:0] SER_REG_COUNT  = 2'd3;

    localparam int SER_ST_RX_READY  = 0;
    localparam int SER_ST_TX_READY  = 1;
    localparam int SER_ST_FRAME_ERR = 2;
    localparam int SER_ST_OVERRUN   = 3;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    function automatic logic [7:0] ser_status(input logic overrun, input logic frame_err,
                                              input logic tx_ready, input logic rx_ready);
        logic [7:0] s;
        s                   = 8'h00;
        s[SER_ST_OVERRUN]   = overrun;
        s[SER_ST_FRAME_ERR] = frame_err;
        s[SER_ST_TX_READY]  = tx_ready;
        s[SER_ST_RX_READY]  = rx_ready;
        return s;
    endfunction

endpackage

// File: rtl/ser_fifo.sv
// Synchronous FIFO; push/pop take effect at the clock edge, head is shown the following cycle.
// A push while full is dropped unless a pop happens in the same cycle; pop on empty is ignored.
module ser_fifo
    import ser_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      push_dat_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
    logic                  do_push;
    logic                  do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A same-cycle pop frees the slot, so a full FIFO can still accept the push.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   cnt_d = cnt_q - (DEPTH_LOG2 + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/ser_port.sv
// 8N1 serial port: RX into a FIFO, TX from a one-byte holding register, 4-register bus slave.
// RX byte visible 1 cycle after stop sample; TX writes while busy are dropped (no backpressure).
module ser_port
    import ser_pkg::*;
#(
    parameter int BIT_CYCLES    = 434,
    parameter int RX_DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       wr,
    input  logic [1:0] addr,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    input  logic       rxd,
    output logic       txd,
    output logic       rx_ready,
    output logic       tx_ready
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);

    logic      rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic      rx_fall;
    rx_state_e rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          rx_push;
    logic          frame_set;

    tx_state_e tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic          txd_q, txd_d;
    logic          tx_accept;

    logic frame_err_q, frame_err_d;
    logic overrun_q, overrun_d;
    logic overrun_set;
    logic clr_frame, clr_overrun;
    logic fifo_pop;
    logic fifo_full, fifo_empty;
    logic [7:0] fifo_head;
    logic [RX_DEPTH_LOG2:0] fifo_count;

    assign rx_fall  = rxd_prev_q & ~rxd_sync_q;
    assign tx_ready = (tx_state_q == TX_IDLE);
    assign rx_ready = ~fifo_empty;
    assign txd      = txd_q;

    // Bus decode
    assign fifo_pop    = en & ~wr & (addr == SER_REG_RXDATA);
    assign tx_accept   = en & wr & (addr == SER_REG_TXDATA) & tx_ready;
    assign clr_frame   = en & wr & (addr == SER_REG_STATUS) & data_in[SER_ST_FRAME_ERR];
    assign clr_overrun = en & wr & (addr == SER_REG_STATUS) & data_in[SER_ST_OVERRUN];

    assign overrun_set = rx_push & fifo_full & ~fifo_pop;
    // A new error in the same cycle as its clear wins.
    assign frame_err_d = (frame_err_q & ~clr_frame) | frame_set;
    assign overrun_d   = (overrun_q & ~clr_overrun) | overrun_set;

    always_comb begin
        case (addr)
            SER_REG_STATUS: data_out = ser_status(overrun_q, frame_err_q, tx_ready, rx_ready);
            SER_REG_RXDATA: data_out = fifo_empty ? 8'h00 : fifo_head;
            SER_REG_COUNT:  data_out = 8'(fifo_count);
            default:        data_out = 8'h00;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_push    = 1'b0;
        frame_set  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_fall) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rxd_sync_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    rx_push    = rxd_sync_q;
                    frame_set  = ~rxd_sync_q;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (tx_accept) begin
                    tx_sh_d    = data_in;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // Line level follows the next state so txd changes on the same edge as the FSM.
        case (tx_state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = tx_sh_d[0];
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta_q  <= 1'b1;
            rxd_sync_q  <= 1'b1;
            rxd_prev_q  <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_sh_q     <= '0;
            txd_q       <= 1'b1;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rxd_meta_q  <= rxd;
            rxd_sync_q  <= rxd_meta_q;
            rxd_prev_q  <= rxd_sync_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_sh_q     <= tx_sh_d;
            txd_q       <= txd_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    ser_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (RX_DEPTH_LOG2)
    ) u_rx_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (rx_push),
        .push_dat_i (rx_sh_q),
        .pop_i      (fifo_pop),
        .head_o     (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

endmodule

// File: tb/tb_ser_port.sv
// Directed bench for ser_port with BIT_CYCLES=16 and a 4-entry receive FIFO.
module tb_ser_port;
    import ser_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       wr;
    logic [1:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       rxd;
    logic       txd;
    logic       rx_ready;
    logic       tx_ready;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] rd;
    logic [7:0] pd;
    logic [9:0] tx_exp;

    ser_port #(
        .BIT_CYCLES    (16),
        .RX_DEPTH_LOG2 (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .wr       (wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .rxd      (rxd),
        .txd      (txd),
        .rx_ready (rx_ready),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = a; data_in = d;
        @(posedge clk);
        #1 en = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        en = 1'b1; wr = 1'b0; addr = a;
        #1 d = data_out;
        @(posedge clk);
        #1 en = 1'b0;
    endtask

    // mode 0: plain; 1: check rx_ready around the stop sample;
    // 2: pop addr1 in the push cycle; 3: clear frame_err in the stop-sample cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int mode,
                              output logic [7:0] pop_dat);
        logic [9:0] bits;
        bits    = {stop_bit, b, 1'b0};
        pop_dat = 8'h00;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            if (mode == 1 && c == 154) chk_eq("rx_ready_pre_stop", 8'(rx_ready), 8'h00);
            if (mode == 1 && c == 155) chk_eq("rx_ready_post_stop", 8'(rx_ready), 8'h01);
            if (mode >= 2 && c == 155) begin en = 1'b0; wr = 1'b0; end
            if (mode == 2 && c == 154) begin
                en = 1'b1; wr = 1'b0; addr = SER_REG_RXDATA;
                #1 pop_dat = data_out;
            end
            if (mode == 3 && c == 154) begin
                en = 1'b1; wr = 1'b1; addr = SER_REG_STATUS; data_in = 8'h04;
            end
            rxd = bits[c / 16];
        end
        @(negedge clk);
        rxd = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; en = 1'b0; wr = 1'b0; addr = 2'd0; data_in = 8'h00; rxd = 1'b1;
        // 1. asynchronous reset before any clock edge
        #2 reset = 1'b1;
        #1;
        chk_eq("rst_txd", 8'(txd), 8'h01);
        chk_eq("rst_tx_ready", 8'(tx_ready), 8'h01);
        chk_eq("rst_rx_ready", 8'(rx_ready), 8'h00);
        bus_read(SER_REG_STATUS, rd); chk_eq("rst_status", rd, 8'h02);
        bus_read(SER_REG_COUNT, rd);  chk_eq("rst_count", rd, 8'h00);
        @(negedge clk) reset = 1'b0;
        idle(5);

        // 2. single RX byte
        send_frame(8'hA5, 1'b1, 1, pd);
        bus_read(SER_REG_COUNT, rd);  chk_eq("rx_count1", rd, 8'h01);
        bus_read(SER_REG_RXDATA, rd); chk_eq("rx_byte", rd, 8'hA5);
        chk_eq("rx_ready_after_pop", 8'(rx_ready), 8'h00);
        bus_read(SER_REG_COUNT, rd);  chk_eq("rx_count0", rd, 8'h00);
        bus_read(SER_REG_RXDATA, rd); chk_eq("empty_read", rd, 8'h00);
        bus_read(SER_REG_COUNT, rd);  chk_eq("empty_read_count", rd, 8'h00);

        // 3. overrun
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0, pd);
        bus_read(SER_REG_COUNT, rd);  chk_eq("ovr_count", rd, 8'h04);
        bus_read(SER_REG_STATUS, rd); chk_eq("ovr_status", rd, 8'h0B);
        for (int i = 1; i <= 4; i++) begin
            bus_read(SER_REG_RXDATA, rd); chk_eq("ovr_order", rd, 8'(i));
        end
        bus_read(SER_REG_STATUS, rd); chk_eq("ovr_sticky", rd, 8'h0A);
        bus_write(SER_REG_STATUS, 8'h08);
        bus_read(SER_REG_STATUS, rd); chk_eq("ovr_cleared", rd, 8'h02);

        // 4. framing error, clear/set collision, glitch
        send_frame(8'h3C, 1'b0, 0, pd);
        bus_read(SER_REG_STATUS, rd); chk_eq("ferr_status", rd, 8'h06);
        bus_read(SER_REG_COUNT, rd);  chk_eq("ferr_count", rd, 8'h00);
        bus_write(SER_REG_STATUS, 8'h04);
        bus_read(SER_REG_STATUS, rd); chk_eq("ferr_cleared", rd, 8'h02);
        send_frame(8'h3C, 1'b0, 3, pd);
        bus_read(SER_REG_STATUS, rd); chk_eq("ferr_clear_collide", rd, 8'h06);
        bus_write(SER_REG_STATUS, 8'h04);
        @(negedge clk) rxd = 1'b0;
        idle(3);
        rxd = 1'b1;
        idle(200);
        bus_read(SER_REG_STATUS, rd); chk_eq("glitch_status", rd, 8'h02);
        bus_read(SER_REG_COUNT, rd);  chk_eq("glitch_count", rd, 8'h00);

        // 5. TX frame, with a write while busy
        bus_read(SER_REG_TXDATA, rd); chk_eq("txdata_read", rd, 8'h00);
        chk_eq("tx_idle_line", 8'(txd), 8'h01);
        tx_exp = {1'b1, 8'h5A, 1'b0};
        bus_write(SER_REG_TXDATA, 8'h5A);
        for (int c = 0; c <= 170; c++) begin
            @(negedge clk);
            if (c == 0)   chk_eq("tx_start_fall", 8'(txd), 8'h00);
            if (c == 5)   chk_eq("tx_busy", 8'(tx_ready), 8'h00);
            if (c < 160 && (c % 16) == 8) chk_eq("tx_bit", 8'(txd), 8'(tx_exp[c / 16]));
            if (c == 159) chk_eq("tx_ready_c159", 8'(tx_ready), 8'h00);
            if (c == 160) chk_eq("tx_ready_c160", 8'(tx_ready), 8'h01);
            if (c == 170) chk_eq("tx_no_second", 8'(txd), 8'h01);
            if (c == 40) begin en = 1'b1; wr = 1'b1; addr = SER_REG_TXDATA; data_in = 8'hFF; end
            if (c == 41) begin en = 1'b0; wr = 1'b0; end
        end

        // 6. simultaneous push and pop when full and when count = 1
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, 0, pd);
        bus_read(SER_REG_COUNT, rd);  chk_eq("full_count", rd, 8'h04);
        send_frame(8'h15, 1'b1, 2, pd);
        chk_eq("full_pushpop_head", pd, 8'h11);
        bus_read(SER_REG_COUNT, rd);  chk_eq("full_pushpop_count", rd, 8'h04);
        bus_read(SER_REG_STATUS, rd); chk_eq("full_pushpop_status", rd, 8'h03);
        for (int i = 0; i < 3; i++) begin
            bus_read(SER_REG_RXDATA, rd); chk_eq("full_order", rd, 8'h12 + 8'(i));
        end
        send_frame(8'h16, 1'b1, 2, pd);
        chk_eq("one_pushpop_head", pd, 8'h15);
        bus_read(SER_REG_COUNT, rd);  chk_eq("one_pushpop_count", rd, 8'h01);
        bus_read(SER_REG_RXDATA, rd); chk_eq("one_pushpop_new", rd, 8'h16);
        bus_read(SER_REG_COUNT, rd);  chk_eq("one_drained", rd, 8'h00);

        // 7. reset mid-frame on both directions
        send_frame(8'h77, 1'b1, 0, pd);
        bus_write(SER_REG_TXDATA, 8'h00);
        idle(30);
        chk_eq("pre_rst_txd", 8'(txd), 8'h00);
        rxd = 1'b0;
        idle(20);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk_eq("mid_rst_txd", 8'(txd), 8'h01);
        chk_eq("mid_rst_tx_ready", 8'(tx_ready), 8'h01);
        chk_eq("mid_rst_rx_ready", 8'(rx_ready), 8'h00);
        rxd = 1'b1;
        bus_read(SER_REG_COUNT, rd);  chk_eq("mid_rst_count", rd, 8'h00);
        @(negedge clk) reset = 1'b0;
        idle(200);
        bus_read(SER_REG_STATUS, rd); chk_eq("post_rst_status", rd, 8'h02);
        bus_read(SER_REG_COUNT, rd);  chk_eq("post_rst_count", rd, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
